// File: rtl/key_debounce.sv
// Synchroniser, debouncer and press/release/long-press event generator for NUM_KEY push-buttons.
// Optional long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
    parameter int NUM_KEY        = 4,
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int LONG_CYC       = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_KEY-1:0] key_in,
    output logic [NUM_KEY-1:0] key_state,
    output logic [NUM_KEY-1:0] key_press,
    output logic [NUM_KEY-1:0] key_release,
    output logic [NUM_KEY-1:0] key_long
);

    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [NUM_KEY-1:0] IDLE_LVL = (KEY_ACTIVE_LOW != 0) ? '1 : '0;

    generate
        if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
            $error("key_debounce: DEBOUNCE_CYC must be at least 2");
        end
        if (LONG_CYC < 2) begin : g_bad_long
            $error("key_debounce: LONG_CYC must be at least 2");
        end
    endgenerate

    logic [NUM_KEY-1:0] sync_p0;
    logic [NUM_KEY-1:0] sync_p1;
    logic [NUM_KEY-1:0] act;
    logic [CNT_W-1:0]   cnt [NUM_KEY];

    // act is 1 while the synchronised pin reads "pressed"
    assign act = sync_p1 ^ IDLE_LVL;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Sync stages hold the released level so nothing is seen as a change after reset
            sync_p0     <= IDLE_LVL;
            sync_p1     <= IDLE_LVL;
            key_state   <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int i = 0; i < NUM_KEY; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // stage p0 -> p1: two-flop synchroniser
            sync_p0 <= key_in;
            sync_p1 <= sync_p0;
            for (int i = 0; i < NUM_KEY; i++) begin
                key_press[i]   <= 1'b0;
                key_release[i] <= 1'b0;
                if (act[i] == key_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]         <= '0;
                    key_state[i]   <= ~key_state[i];
                    key_press[i]   <= ~key_state[i];
                    key_release[i] <= key_state[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int                HOLD_W   = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYC - 2);

    logic [HOLD_W-1:0] hold [NUM_KEY];

    // Pulse is registered one count early so it lands with the counter reaching LONG_CYC-1
    always_ff @(posedge clk) begin
        if (rst) begin
            key_long <= '0;
            for (int i = 0; i < NUM_KEY; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEY; i++) begin
                key_long[i] <= key_state[i] && (hold[i] == HOLD_PRE);
                if (!key_state[i]) begin
                    hold[i] <= '0;
                end else if (hold[i] != HOLD_MAX) begin
                    hold[i] <= hold[i] + HOLD_W'(1);
                end
            end
        end
    end
`else
    assign key_long = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: reset, latency, glitch rejection, simultaneous keys,
// mid-count reset and long-press behaviour (long-press expectations follow KEY_LONG_PRESS_EN).
module tb_key_debounce;

    localparam int NK = 2;
    localparam int DC = 8;
    localparam int LC = 20;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_ON = 1'b1;
`else
    localparam bit LONG_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_in = 2'b11;
    logic [NK-1:0] key_state;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    key_debounce #(
        .NUM_KEY       (NK),
        .DEBOUNCE_CYC  (DC),
        .KEY_ACTIVE_LOW(1),
        .LONG_CYC      (LC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [NK-1:0] seen;
        rst = 1'b1;
        key_in = 2'b11;
        tick();
        tick();
        n_cmp++;
        if (key_state !== 2'b00) begin n_err++; $display("FAIL reset_state got=%b want=00", key_state); end
        n_cmp++;
        if (key_press !== 2'b00) begin n_err++; $display("FAIL reset_press got=%b want=00", key_press); end
        n_cmp++;
        if (key_release !== 2'b00) begin n_err++; $display("FAIL reset_release got=%b want=00", key_release); end
        n_cmp++;
        if (key_long !== 2'b00) begin n_err++; $display("FAIL reset_long got=%b want=00", key_long); end
        rst = 1'b0;
        seen = 2'b00;
        for (int k = 0; k < 50; k++) begin
            tick();
            seen = seen | key_state | key_press | key_release | key_long;
        end
        n_cmp++;
        if (seen !== 2'b00) begin n_err++; $display("FAIL idle_activity got=%b want=00", seen); end
    endtask

    task automatic test_latency();
        logic [NK-1:0] exp_p;
        logic [NK-1:0] exp_s;
        key_in = 2'b10;
        for (int k = 0; k <= 10; k++) begin
            tick();
            exp_p = (k == 9) ? 2'b01 : 2'b00;
            exp_s = (k >= 9) ? 2'b01 : 2'b00;
            n_cmp++;
            if (key_press !== exp_p || key_state !== exp_s) begin
                n_err++;
                $display("FAIL press_latency edge=%0d got press=%b state=%b want press=%b state=%b",
                         k, key_press, key_state, exp_p, exp_s);
            end
        end
        key_in = 2'b11;
        for (int k = 0; k <= 10; k++) begin
            tick();
            exp_p = (k == 9) ? 2'b01 : 2'b00;
            exp_s = (k >= 9) ? 2'b00 : 2'b01;
            n_cmp++;
            if (key_release !== exp_p || key_state !== exp_s || key_press !== 2'b00) begin
                n_err++;
                $display("FAIL release_latency edge=%0d got rel=%b state=%b press=%b want rel=%b state=%b press=00",
                         k, key_release, key_state, key_press, exp_p, exp_s);
            end
        end
    endtask

    task automatic test_glitch();
        logic [NK-1:0] seen;
        seen = 2'b00;
        for (int r = 0; r < 4; r++) begin
            key_in = 2'b10;
            for (int k = 0; k < 5; k++) begin
                tick();
                seen = seen | key_state | key_press;
            end
            key_in = 2'b11;
            for (int k = 0; k < 5; k++) begin
                tick();
                seen = seen | key_state | key_press;
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            seen = seen | key_state | key_press | key_release;
        end
        n_cmp++;
        if (seen !== 2'b00) begin n_err++; $display("FAIL glitch_reject got=%b want=00", seen); end
    endtask

    task automatic test_simultaneous();
        logic [NK-1:0] exp_p;
        key_in = 2'b00;
        for (int k = 0; k < 30; k++) begin
            tick();
            exp_p = (k == 9) ? 2'b11 : 2'b00;
            n_cmp++;
            if (key_press !== exp_p || key_release !== 2'b00) begin
                n_err++;
                $display("FAIL both_press edge=%0d got press=%b rel=%b want press=%b rel=00",
                         k, key_press, key_release, exp_p);
            end
        end
        key_in = 2'b11;
        for (int k = 0; k <= 11; k++) begin
            tick();
            exp_p = (k == 9) ? 2'b11 : 2'b00;
            n_cmp++;
            if (key_release !== exp_p || key_press !== 2'b00) begin
                n_err++;
                $display("FAIL both_release edge=%0d got rel=%b press=%b want rel=%b press=00",
                         k, key_release, key_press, exp_p);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [NK-1:0] exp_p;
        logic [NK-1:0] exp_s;
        key_in = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (key_state !== 2'b00 || key_press !== 2'b00) begin
                n_err++;
                $display("FAIL pre_rst edge=%0d got state=%b press=%b want 00/00", k, key_state, key_press);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (key_state !== 2'b00 || key_press !== 2'b00 || key_release !== 2'b00) begin
            n_err++;
            $display("FAIL rst_edge_pulse got state=%b press=%b rel=%b want 00", key_state, key_press, key_release);
        end
        for (int j = 1; j <= 11; j++) begin
            tick();
            exp_p = (j == 10) ? 2'b10 : 2'b00;
            exp_s = (j >= 10) ? 2'b10 : 2'b00;
            n_cmp++;
            if (key_press !== exp_p || key_state !== exp_s) begin
                n_err++;
                $display("FAIL restart_count j=%0d got press=%b state=%b want press=%b state=%b",
                         j, key_press, key_state, exp_p, exp_s);
            end
        end
        key_in = 2'b11;
        for (int k = 0; k <= 10; k++) begin
            tick();
            exp_p = (k == 9) ? 2'b10 : 2'b00;
            n_cmp++;
            if (key_release !== exp_p) begin
                n_err++;
                $display("FAIL key1_release edge=%0d got=%b want=%b", k, key_release, exp_p);
            end
        end
    endtask

    task automatic test_long_press();
        logic [NK-1:0] exp_l;
        logic [NK-1:0] exp_r;
        key_in = 2'b10;
        for (int k = 0; k <= 9; k++) tick();
        n_cmp++;
        if (key_press !== 2'b01) begin n_err++; $display("FAIL long_press_start got=%b want=01", key_press); end
        for (int j = 1; j <= 40; j++) begin
            tick();
            exp_l = (LONG_ON && j == 19) ? 2'b01 : 2'b00;
            n_cmp++;
            if (key_long !== exp_l) begin
                n_err++;
                $display("FAIL long_pulse j=%0d got=%b want=%b", j, key_long, exp_l);
            end
        end
        key_in = 2'b11;
        for (int k = 0; k <= 11; k++) begin
            tick();
            exp_r = (k == 9) ? 2'b01 : 2'b00;
            n_cmp++;
            if (key_release !== exp_r || key_long !== 2'b00) begin
                n_err++;
                $display("FAIL long_release edge=%0d got rel=%b long=%b want rel=%b long=00",
                         k, key_release, key_long, exp_r);
            end
        end
        // short press: released well before the long-press point
        key_in = 2'b10;
        for (int k = 0; k <= 9; k++) tick();
        n_cmp++;
        if (key_press !== 2'b01) begin n_err++; $display("FAIL short_press_start got=%b want=01", key_press); end
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (j == 5) key_in = 2'b11;
            exp_r = (j == 15) ? 2'b01 : 2'b00;
            n_cmp++;
            if (key_long !== 2'b00 || key_release !== exp_r) begin
                n_err++;
                $display("FAIL short_press j=%0d got long=%b rel=%b want long=00 rel=%b",
                         j, key_long, key_release, exp_r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
        test_long_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
